// File: rtl/mem_pkg.sv
// Shared definitions for the mem_port memory access unit.
//   mem_state_t  : access FSM states
//   SIZE_BYTE/SIZE_WORD : encodings of the request size field
//   RAM_BE_WORD  : byte enables driven to the RAM (always full word)
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_FAULT   = 3'd4
  } mem_state_t;

  localparam logic       SIZE_BYTE   = 1'b0;
  localparam logic       SIZE_WORD   = 1'b1;
  localparam logic [1:0] RAM_BE_WORD = 2'b11;

endpackage

// File: rtl/mem_port_if.sv
// CPU-side load/store request bus of mem_port.
//   master (CPU)      : drives req, we, size, sext, addr, wdata
//   slave  (mem_port) : drives ready, ack, err, rdata
interface mem_port_if #(
  parameter int ADDR_W = 16
) ();

  logic              req;
  logic              ready;
  logic              we;
  logic              size;
  logic              sext;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic              ack;
  logic              err;
  logic [15:0]       rdata;

  modport master (
    output req, we, size, sext, addr, wdata,
    input  ready, ack, err, rdata
  );

  modport slave (
    input  req, we, size, sext, addr, wdata,
    output ready, ack, err, rdata
  );

endinterface

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane logic for mem_port.
//   word       in  : word read from the RAM
//   hi         in  : selected lane (0 = [7:0], 1 = [15:8])
//   size       in  : SIZE_BYTE / SIZE_WORD
//   sext       in  : sign-extend byte loads
//   wbyte      in  : byte to be stored
//   load_data  out : load result (word, or extended byte lane)
//   store_data out : word with the selected lane replaced by wbyte
module mem_byte_lane
  import mem_pkg::*;
(
  input  logic [15:0] word,
  input  logic        hi,
  input  logic        size,
  input  logic        sext,
  input  logic [7:0]  wbyte,
  output logic [15:0] load_data,
  output logic [15:0] store_data
);

  logic [7:0] lane;

  always_comb begin
    lane = hi ? word[15:8] : word[7:0];

    if (size == SIZE_WORD) begin
      load_data = word;
    end else begin
      load_data = {{8{sext & lane[7]}}, lane};
    end

    store_data = hi ? {wbyte, word[7:0]} : {word[15:8], wbyte};
  end

endmodule

// File: rtl/mem_port.sv
// CPU load/store unit in front of a single-port synchronous RAM with
// one-cycle registered read data. Byte stores are done as read-modify-write
// so the RAM only ever sees full-word writes.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : CPU request bus (slave side)
//   ram_addr   : RAM word index (registered)
//   ram_wdata  : RAM write data (registered)
//   ram_be     : RAM byte enables, always full word
//   ram_we     : RAM write enable (registered, one cycle per store)
//   ram_rdata  : RAM read data, valid the cycle after ram_addr is latched
module mem_port
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_port_if.slave   bus,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic [1:0]  ram_be,
  output logic        ram_we,
  input  logic [15:0] ram_rdata
);

  mem_state_t  state_q, state_d;
  logic        lat_we_q, lat_we_d;
  logic        lat_size_q, lat_size_d;
  logic        lat_sext_q, lat_sext_d;
  logic        lat_hi_q, lat_hi_d;
  logic [7:0]  lat_wbyte_q, lat_wbyte_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [15:0] ram_wdata_q, ram_wdata_d;
  logic        ram_we_q, ram_we_d;

  logic [15:0] load_data;
  logic [15:0] store_data;

  mem_byte_lane u_lane (
    .word       (ram_rdata),
    .hi         (lat_hi_q),
    .size       (lat_size_q),
    .sext       (lat_sext_q),
    .wbyte      (lat_wbyte_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold its value.
  always_comb begin
    state_d     = state_q;
    lat_we_d    = lat_we_q;
    lat_size_d  = lat_size_q;
    lat_sext_d  = lat_sext_q;
    lat_hi_d    = lat_hi_q;
    lat_wbyte_d = lat_wbyte_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          lat_we_d    = bus.we;
          lat_size_d  = bus.size;
          lat_sext_d  = bus.sext;
          lat_hi_d    = bus.addr[0];
          lat_wbyte_d = bus.wdata[7:0];
          if (bus.size == SIZE_WORD && bus.addr[0]) begin
            // Misaligned word: report it without touching the RAM.
            state_d = ST_FAULT;
          end else begin
            ram_addr_d = 16'(bus.addr[ADDR_W-1:1]);
            if (bus.we && bus.size == SIZE_WORD) begin
              state_d     = ST_WR;
              ram_wdata_d = bus.wdata;
              ram_we_d    = 1'b1;
            end else begin
              // Loads and byte stores both need the current word first.
              state_d = ST_RD_ADDR;
            end
          end
        end
      end
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (lat_we_q) begin
          state_d     = ST_WR;
          ram_wdata_d = store_data;
          ram_we_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
          rdata_d = load_data;
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
        ack_d   = 1'b1;
      end
      ST_FAULT: begin
        state_d = ST_IDLE;
        ack_d   = 1'b1;
        err_d   = 1'b1;
        rdata_d = 16'h0000;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lat_we_q    <= 1'b0;
      lat_size_q  <= SIZE_BYTE;
      lat_sext_q  <= 1'b0;
      lat_hi_q    <= 1'b0;
      lat_wbyte_q <= 8'h00;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 16'h0000;
      ram_addr_q  <= 16'h0000;
      ram_wdata_q <= 16'h0000;
      ram_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_we_q    <= lat_we_d;
      lat_size_q  <= lat_size_d;
      lat_sext_q  <= lat_sext_d;
      lat_hi_q    <= lat_hi_d;
      lat_wbyte_q <= lat_wbyte_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
    end
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign ram_be    = RAM_BE_WORD;

endmodule

// File: tb/tb_mem_port.sv
// Self-checking bench for mem_port: directed cases with literal expectations,
// then randomized requests against a word-array reference model.
module tb_mem_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic [1:0]  ram_be;
  logic        ram_we;

  mem_port_if #(.ADDR_W(16)) bus ();

  mem_port #(.ADDR_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_be    (ram_be),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with registered read data.
  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[7:0]];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of the outstanding request, expressed as cycle numbers.
  bit          mon_en       = 1'b0;
  bit          pending      = 1'b0;
  bit          exp_err      = 1'b0;
  bit          exp_set      = 1'b0;
  int          exp_ack_cyc  = -1;
  int          exp_we_cyc   = -1;
  logic [15:0] exp_val      = 16'h0;
  logic [15:0] held         = 16'h0;
  logic [15:0] exp_ram_addr = 16'h0;
  logic [15:0] exp_we_data  = 16'h0;

  always @(negedge clk) begin
    if (mon_en) begin
      bit ack_due;
      bit we_due;
      ack_due = pending && (cyc == exp_ack_cyc);
      we_due  = (cyc == exp_we_cyc);
      check("ready", bus.ready, !pending || ack_due);
      check("ack", bus.ack, ack_due);
      check("err", bus.err, ack_due && exp_err);
      if (ack_due) begin
        if (exp_set) held = exp_val;
        pending = 1'b0;
      end
      check("rdata", bus.rdata, held);
      check("ram_we", ram_we, we_due);
      check("ram_addr", ram_addr, exp_ram_addr);
      check("ram_be", ram_be, 16'h0003);
      if (we_due) check("ram_wdata", ram_wdata, exp_we_data);
    end
  end

  // Presents one request as soon as the model says the port is free.
  // junk: drive random ignored requests while busy.
  // abort: pull reset during the read-back cycle of a byte store.
  task automatic issue(input bit iwe, input bit isize, input bit isext,
                       input logic [15:0] iaddr, input logic [15:0] iwdata,
                       input bit junk, input bit abort);
    int          e;
    int          sh;
    logic [7:0]  idx;
    logic [7:0]  b;
    logic [15:0] old;
    logic [15:0] nv;
    do begin
      @(negedge clk);
      #1;
      if (pending && junk && ($urandom_range(0, 1) == 1)) begin
        bus.req   = 1'b1;
        bus.we    = 1'($urandom_range(0, 1));
        bus.size  = 1'($urandom_range(0, 1));
        bus.sext  = 1'($urandom_range(0, 1));
        bus.addr  = 16'($urandom);
        bus.wdata = 16'($urandom);
      end else begin
        bus.req = 1'b0;
      end
    end while (pending);

    bus.req   = 1'b1;
    bus.we    = iwe;
    bus.size  = isize;
    bus.sext  = isext;
    bus.addr  = iaddr;
    bus.wdata = iwdata;

    e       = cyc + 1;
    idx     = iaddr[8:1];
    sh      = iaddr[0] ? 8 : 0;
    exp_set = 1'b0;
    exp_err = 1'b0;
    if (isize && iaddr[0]) begin
      exp_ack_cyc = e + 1;
      exp_err     = 1'b1;
      exp_set     = 1'b1;
      exp_val     = 16'h0000;
    end else begin
      exp_ram_addr = iaddr >> 1;
      if (iwe && isize) begin
        exp_we_cyc   = e;
        exp_we_data  = iwdata;
        ref_mem[idx] = iwdata;
        exp_ack_cyc  = e + 1;
      end else if (iwe) begin
        old         = ref_mem[idx];
        nv          = (old & ~(16'h00FF << sh)) | (16'(iwdata[7:0]) << sh);
        exp_we_cyc  = e + 2;
        exp_we_data = nv;
        if (!abort) ref_mem[idx] = nv;
        exp_ack_cyc = e + 3;
      end else begin
        if (isize) begin
          exp_val = ref_mem[idx];
        end else begin
          b       = 8'(ref_mem[idx] >> sh);
          exp_val = (isext && b >= 8'h80) ? 16'(b) + 16'hFF00 : 16'(b);
        end
        exp_set     = 1'b1;
        exp_ack_cyc = e + 2;
      end
    end
    pending = 1'b1;

    if (abort) begin
      @(negedge clk);
      #1 bus.req = 1'b0;
      @(negedge clk);
      #1;
      rst_n        = 1'b0;
      pending      = 1'b0;
      exp_ack_cyc  = -1;
      exp_we_cyc   = -1;
      held         = 16'h0000;
      exp_ram_addr = 16'h0000;
      @(negedge clk);
      #1 rst_n = 1'b1;
    end
  endtask

  task automatic wait_done();
    do begin
      @(negedge clk);
      #1 bus.req = 1'b0;
    end while (pending);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] save;
    logic [15:0] a;
    for (int i = 0; i < 256; i++) begin
      a          = 16'($urandom);
      mem[i]     = a;
      ref_mem[i] = a;
    end
    mem[8'h40]     = 16'hA5C3;
    ref_mem[8'h40] = 16'hA5C3;

    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.size  = 1'b0;
    bus.sext  = 1'b0;
    bus.addr  = 16'h0;
    bus.wdata = 16'h0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", bus.ack, 16'h0);
    check("rst_err", bus.err, 16'h0);
    check("rst_ram_we", ram_we, 16'h0);
    check("rst_rdata", bus.rdata, 16'h0);
    check("rst_ram_addr", ram_addr, 16'h0);
    check("rst_ram_wdata", ram_wdata, 16'h0);
    check("rst_ready", bus.ready, 16'h1);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Preloaded word and its byte lanes.
    issue(1'b0, 1'b1, 1'b0, 16'h0080, 16'h0, 1'b0, 1'b0); wait_done();
    check("lit_word_load", bus.rdata, 16'hA5C3);
    issue(1'b0, 1'b0, 1'b1, 16'h0081, 16'h0, 1'b0, 1'b0); wait_done();
    check("lit_b81_sext", bus.rdata, 16'hFFA5);
    issue(1'b0, 1'b0, 1'b0, 16'h0081, 16'h0, 1'b0, 1'b0); wait_done();
    check("lit_b81_zext", bus.rdata, 16'h00A5);
    issue(1'b0, 1'b0, 1'b1, 16'h0080, 16'h0, 1'b0, 1'b0); wait_done();
    check("lit_b80_sext", bus.rdata, 16'hFFC3);
    issue(1'b0, 1'b0, 1'b0, 16'h0080, 16'h0, 1'b1, 1'b0); wait_done();
    check("lit_b80_zext", bus.rdata, 16'h00C3);

    // Byte store read-modify-write, then readback.
    issue(1'b1, 1'b0, 1'b0, 16'h0081, 16'h1234, 1'b1, 1'b0); wait_done();
    check("lit_bstore_mem", mem[8'h40], 16'h34C3);
    issue(1'b0, 1'b1, 1'b0, 16'h0080, 16'h0, 1'b0, 1'b0); wait_done();
    check("lit_bstore_rb", bus.rdata, 16'h34C3);

    // Word store and readback.
    issue(1'b1, 1'b1, 1'b0, 16'h0100, 16'hBEEF, 1'b0, 1'b0); wait_done();
    check("lit_wstore_mem", mem[8'h80], 16'hBEEF);
    issue(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0, 1'b0, 1'b0); wait_done();
    check("lit_wstore_rb", bus.rdata, 16'hBEEF);

    // Misaligned word, alone and followed back-to-back.
    issue(1'b0, 1'b1, 1'b0, 16'h0081, 16'h0, 1'b0, 1'b0); wait_done();
    check("lit_fault_err", bus.err, 16'h1);
    check("lit_fault_rdata", bus.rdata, 16'h0);
    issue(1'b1, 1'b1, 1'b0, 16'h0083, 16'h5555, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 16'h0080, 16'h0, 1'b0, 1'b0); wait_done();
    check("lit_b2b_load", bus.rdata, 16'h34C3);

    // Reset during the read-back of a byte store.
    save = mem[8'h41];
    issue(1'b1, 1'b0, 1'b0, 16'h0083, 16'h00EE, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("lit_abort_mem", mem[8'h41], save);

    // Randomized traffic, including ignored requests and aborts.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) a = 16'h0100 + 16'($urandom_range(0, 3));
      else                           a = 16'h0080 + 16'($urandom_range(0, 31));
      begin
        bit rwe;
        bit rsize;
        bit rabort;
        rwe    = 1'($urandom_range(0, 1));
        rsize  = 1'($urandom_range(0, 1));
        rabort = rwe && !rsize && ($urandom_range(0, 19) == 0);
        issue(rwe, rsize, 1'($urandom_range(0, 1)), a, 16'($urandom),
              1'($urandom_range(0, 1)), rabort);
      end
    end
    wait_done();
    repeat (3) @(negedge clk);

    for (int i = 0; i < 256; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
